// File: rtl/timer_dispatcher.sv
// Feeds duration requests from a small FIFO to the 5-bit countdown timer one at a time,
// waiting for each expiry pulse (or a watchdog abort) before issuing the next.
module timer_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 40
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  input  logic [4:0]                   req_val,
  output logic                         req_ready,
  output logic [4:0]                   tmr_in,
  output logic                         tmr_in_valid,
  input  logic                         tmr_out_valid,
  output logic                         done,
  output logic [4:0]                   done_val,
  output logic                         timeout,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic                         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t        state, state_nxt;
  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    wdog, wdog_nxt;
  logic          push, pop, full;
  logic [4:0]    head;
  logic [4:0]    tmr_in_nxt, done_val_nxt;
  logic          tiv_nxt, done_nxt, timeout_nxt, err_nxt;

  // Readiness depends on occupancy alone, so a same-edge pop never frees a slot early.
  assign full      = (count == CW'(DEPTH));
  assign push      = req_valid && !full;
  assign head      = mem[rd_ptr];
  assign req_ready = !full;
  assign pending   = count;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    wdog_nxt     = wdog;
    tmr_in_nxt   = tmr_in;
    tiv_nxt      = 1'b0;
    done_nxt     = 1'b0;
    done_val_nxt = done_val;
    timeout_nxt  = 1'b0;
    err_nxt      = err;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          // Zero-length requests complete immediately without touching the timer.
          if (head == 5'd0) begin
            done_nxt     = 1'b1;
            done_val_nxt = 5'd0;
          end else begin
            tmr_in_nxt = head;
            tiv_nxt    = 1'b1;
            state_nxt  = LOAD;
          end
        end
      end
      LOAD: begin
        wdog_nxt  = 8'd0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (wdog != 8'hFF) wdog_nxt = wdog + 8'd1;
        // Expiry wins over the watchdog when both land on the same edge.
        if (tmr_out_valid) begin
          done_nxt     = 1'b1;
          done_val_nxt = tmr_in;
          state_nxt    = IDLE;
        end else if (wdog == WD_LAST) begin
          timeout_nxt = 1'b1;
          err_nxt     = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wdog         <= 8'd0;
      tmr_in       <= 5'd0;
      tmr_in_valid <= 1'b0;
      done         <= 1'b0;
      done_val     <= 5'd0;
      timeout      <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      wdog         <= wdog_nxt;
      tmr_in       <= tmr_in_nxt;
      tmr_in_valid <= tiv_nxt;
      done         <= done_nxt;
      done_val     <= done_val_nxt;
      timeout      <= timeout_nxt;
      err          <= err_nxt;
    end
  end

endmodule

// File: tb/tb_timer_dispatcher.sv
// Randomized bench for timer_dispatcher: a stub timer drives expiry pulses and a
// queue-based reference model predicts every output on every cycle.
module tb_timer_dispatcher;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 40;
  localparam int CW      = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [4:0]    req_val = 5'd0;
  logic          tmr_out_valid = 1'b0;
  logic          req_ready;
  logic [4:0]    tmr_in;
  logic          tmr_in_valid;
  logic          done;
  logic [4:0]    done_val;
  logic          timeout;
  logic          err;
  logic [CW-1:0] pending;
  logic          busy;

  timer_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_val       (req_val),
    .req_ready     (req_ready),
    .tmr_in        (tmr_in),
    .tmr_in_valid  (tmr_in_valid),
    .tmr_out_valid (tmr_out_valid),
    .done          (done),
    .done_val      (done_val),
    .timeout       (timeout),
    .err           (err),
    .pending       (pending),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queued values plus the edge at which the in-flight request was popped.
  int q[$];
  bit inflight;
  int pop_edge;
  int inflight_val;
  int edge_n = 0;
  int pulse_edge = -100;
  int fire_pct = 100;
  bit exp_done, exp_timeout, exp_tiv, exp_err, exp_busy, exp_ready;
  int exp_done_val, exp_tin, exp_pending;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic modelReset();
    q.delete();
    inflight     = 1'b0;
    exp_done     = 1'b0;
    exp_done_val = 0;
    exp_timeout  = 1'b0;
    exp_tiv      = 1'b0;
    exp_tin      = 0;
    exp_err      = 1'b0;
    exp_busy     = 1'b0;
    exp_ready    = 1'b1;
    exp_pending  = 0;
    pulse_edge   = -100;
  endtask

  task automatic modelEdge(input bit rv, input int rval, input bit tov);
    int n = edge_n;
    bit was_inflight = inflight;
    int depth0 = q.size();
    exp_done    = 1'b0;
    exp_timeout = 1'b0;
    exp_tiv     = 1'b0;
    if (was_inflight && n >= pop_edge + 2) begin
      if (tov) begin
        exp_done     = 1'b1;
        exp_done_val = inflight_val;
        inflight     = 1'b0;
      end else if (n == pop_edge + 1 + TIMEOUT) begin
        exp_timeout = 1'b1;
        exp_err     = 1'b1;
        inflight    = 1'b0;
      end
    end
    if (!was_inflight && depth0 > 0) begin
      int v;
      v = q.pop_front();
      if (v == 0) begin
        exp_done     = 1'b1;
        exp_done_val = 0;
      end else begin
        exp_tiv      = 1'b1;
        exp_tin      = v;
        inflight     = 1'b1;
        pop_edge     = n;
        inflight_val = v;
      end
    end
    if (rv && depth0 < DEPTH) q.push_back(rval);
    exp_pending = q.size();
    exp_ready   = (q.size() < DEPTH);
    exp_busy    = inflight;
  endtask

  task automatic checkAll();
    checkOutput("req_ready", int'(req_ready), int'(exp_ready));
    checkOutput("pending", int'(pending), exp_pending);
    checkOutput("busy", int'(busy), int'(exp_busy));
    checkOutput("tmr_in_valid", int'(tmr_in_valid), int'(exp_tiv));
    checkOutput("tmr_in", int'(tmr_in), exp_tin);
    checkOutput("done", int'(done), int'(exp_done));
    if (exp_done) checkOutput("done_val", int'(done_val), exp_done_val);
    checkOutput("timeout", int'(timeout), int'(exp_timeout));
    checkOutput("err", int'(err), int'(exp_err));
  endtask

  // One clock cycle: check outputs, act as the timer, drive inputs, advance the model.
  task automatic applyStimulus(input bit rv, input logic [4:0] rval, input bit stray);
    @(negedge clk);
    checkAll();
    if (rst_n && exp_tiv && $urandom_range(99) < fire_pct)
      pulse_edge = edge_n + exp_tin + 2;
    req_valid     = rv;
    req_val       = rval;
    tmr_out_valid = stray || (edge_n + 1 == pulse_edge);
    @(posedge clk);
    edge_n++;
    if (rst_n) modelEdge(rv, int'(rval), tmr_out_valid);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 1'b0);
  endtask

  task automatic resetNow();
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkOutput("rst_done_val", int'(done_val), 0);
    idle(2);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    modelReset();
    #1;
    checkAll();
    checkOutput("rst_done_val", int'(done_val), 0);
    idle(2);
    #1;
    rst_n = 1'b1;

    fire_pct = 100;
    applyStimulus(1'b1, 5'd5, 1'b0);
    idle(12);
    applyStimulus(1'b1, 5'd3, 1'b0);
    applyStimulus(1'b1, 5'd1, 1'b0);
    idle(16);
    applyStimulus(1'b1, 5'd0, 1'b0);
    idle(4);

    fire_pct = 0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 5'($urandom_range(31, 1)), 1'b0);
    idle(5 * (TIMEOUT + 3));

    applyStimulus(1'b1, 5'd7, 1'b0);
    idle(TIMEOUT + 6);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 5'd0, 1'b1);
    idle(3);

    applyStimulus(1'b1, 5'd9, 1'b0);
    applyStimulus(1'b1, 5'd4, 1'b0);
    applyStimulus(1'b1, 5'd6, 1'b0);
    idle(5);
    resetNow();
    fire_pct = 100;
    idle(20);

    fire_pct = 85;
    for (int i = 0; i < 2500; i++) begin
      bit rv;
      bit stray;
      logic [4:0] v;
      rv    = ($urandom_range(99) < 30);
      stray = ($urandom_range(99) < 3);
      v     = ($urandom_range(4) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
      applyStimulus(rv, v, stray);
      if (i == 1200) resetNow();
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_dispatcher.md
Name: timer_dispatcher

Overview:
Upstream feeder for the 5-bit countdown timer stage. It queues duration requests in a small FIFO and issues them to the timer one at a time over the timer's load port (5-bit value plus one-cycle load strobe). It then waits for the timer's expiry pulse before issuing the next request. It reports per-request completion, zero-length completion and watchdog timeouts.

Parameters:
DEPTH, 4, FIFO entries; power of two, range 2..16.
TIMEOUT, 40, WAIT cycles without an expiry pulse before the request is aborted; range 33..255.

Ports:
clk  input  1  clock; all flops rise-edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request strobe; a request is accepted on an edge where req_valid && req_ready.
req_val  input  5  requested duration, 0..31.
req_ready  output  1  high when the FIFO is not full.
tmr_in  output  5  load value to the timer; registered.
tmr_in_valid  output  1  one-cycle load strobe to the timer; registered.
tmr_out_valid  input  1  expiry pulse from the timer.
done  output  1  one-cycle pulse when a request completes; registered.
done_val  output  5  value of the completed request; valid while done is high.
timeout  output  1  one-cycle pulse when the watchdog aborts a request.
err  output  1  sticky; set on the first timeout, cleared only by reset.
pending  output  $clog2(DEPTH+1)  FIFO occupancy.
busy  output  1  high in LOAD and WAIT.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: req_ready=1; tmr_in=0; tmr_in_valid=0; done=0; done_val=0; timeout=0; err=0; pending=0; busy=0.
- Reset state: FSM in IDLE, FIFO empty, watchdog counter 0.
- Reset mid-operation: reset in any state discards all queued and in-flight requests with no done pulse. The state after reset release is identical to the power-up state.
- FIFO:
  - Writes on req_valid && req_ready.
  - req_ready = !full, computed from occupancy only. A push into a full FIFO is refused even if a pop happens on the same edge.
  - A push and a pop on the same edge leave pending unchanged.
- FSM state IDLE:
  - FIFO empty: stay in IDLE.
  - Head == 0: pop the head. done=1 and done_val=0 on the next cycle. The timer is not loaded, and the FSM stays in IDLE.
  - Head != 0: pop the head, register tmr_in=head and tmr_in_valid=1, go to LOAD.
- FSM state LOAD (exactly 1 cycle):
  - tmr_in_valid is high during this cycle.
  - Next edge: tmr_in_valid=0, clear the watchdog, go to WAIT.
  - tmr_out_valid is ignored in LOAD.
- FSM state WAIT:
  - The watchdog increments every cycle.
  - If tmr_out_valid is sampled high: done=1, done_val=tmr_in, go to IDLE.
  - Else, if the watchdog reaches TIMEOUT-1: timeout=1, err=1, go to IDLE. done is not asserted for the aborted request.
  - Expiry takes priority over timeout on the same edge.
- tmr_out_valid outside WAIT is ignored. The timer re-fires every 32 cycles after wrap, so stray pulses are expected.
- tmr_in holds its last loaded value outside LOAD.
- Timer contract relied upon: for a load of value v sampled at edge L, the expiry pulse appears in the cycle after edge L+v.
- Latency: for a request of value v != 0 accepted at edge A into an empty FIFO with the FSM in IDLE:
  - tmr_in_valid is high after edge A+1.
  - The timer samples the load at edge A+2.
  - done rises after edge A+v+3.
- Back-to-back: the next request is popped on the edge after done rises. The gap between loads is v+3 cycles.
- Zero request: done is high one cycle after the pop edge.
- Arithmetic: the watchdog is 8-bit and saturates; pending never exceeds DEPTH.

Test Plan:
- Reset, then push 5 at edge A -> tmr_in_valid=1 with tmr_in=5 after A+1; done=1, done_val=5 after A+8 only; pending returns to 0.
- Push 3 and then 1 on consecutive edges -> two loads, done_val=3 then done_val=1, in order; loads are 6 cycles apart.
- Push 0 -> done=1, done_val=0 one cycle after the pop; tmr_in_valid is never asserted; busy stays 0.
- Hold req_valid with FIFO output blocked (stub timer never fires) and DEPTH=4 -> 4 accepted while busy; req_ready=0 at pending=4; 5th value not accepted; the 4 queued requests dispatch in order after the watchdog aborts.
- Stub timer silent after a load of 7 -> timeout pulse exactly TIMEOUT=40 cycles after entering WAIT; err stays 1; no done; a stray tmr_out_valid in IDLE produces no done.
- Assert rst_n low mid-WAIT with 2 requests queued -> all outputs return to reset values immediately; no done after release; pending=0.
